// File: rtl/spi_aes_initiator.sv
// SPI mode-0 initiator for an AES subnode: shifts out {msg_in, key_in} MSB first,
// waits for the subnode to compute, then reads back one result block.
module spi_aes_initiator #(
   parameter int nk      = 8,
   parameter int nb      = 4,
   parameter int CLK_DIV = 2
) (
   input  logic                in_clk,
   input  logic                rst,
   input  logic                start,
   input  logic [32*nb-1:0]    msg_in,
   input  logic [32*nk-1:0]    key_in,
   input  logic                miso,
   output logic                sclk,
   output logic                cs,
   output logic                mosi,
   output logic                busy,
   output logic                done,
   output logic [32*nb-1:0]    result_out
);

   localparam int TX_BITS = 32*nb + 32*nk;
   localparam int RX_BITS = 32*nb;
   localparam int CNT_W   = $clog2(TX_BITS + 1);
   localparam int DIV_W   = $clog2(2*CLK_DIV);

   localparam logic [DIV_W-1:0] HALF_LEN = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] GAP_LEN  = DIV_W'(2*CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [CNT_W-1:0] TX_LEN   = CNT_W'(TX_BITS);
   localparam logic [CNT_W-1:0] RX_LEN   = CNT_W'(RX_BITS);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {IDLE, SETUP, TX, GAP, RX, FINISH} state_t;

   state_t               state_reg, state_next;
   logic [DIV_W-1:0]     div_reg, div_next;
   logic [CNT_W-1:0]     bit_reg, bit_next;
   logic [TX_BITS-1:0]   tx_reg, tx_next;
   logic [RX_BITS-1:0]   rx_reg, rx_next;
   logic [RX_BITS-1:0]   result_reg, result_next;
   logic                 sclk_reg, sclk_next;
   logic                 cs_reg, cs_next;
   logic                 mosi_reg, mosi_next;
   logic                 busy_reg, busy_next;
   logic                 done_reg, done_next;

   always_ff @(posedge in_clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         div_reg    <= '0;
         bit_reg    <= '0;
         tx_reg     <= '0;
         rx_reg     <= '0;
         result_reg <= '0;
         sclk_reg   <= 1'b0;
         cs_reg     <= 1'b1;
         mosi_reg   <= 1'b0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         div_reg    <= div_next;
         bit_reg    <= bit_next;
         tx_reg     <= tx_next;
         rx_reg     <= rx_next;
         result_reg <= result_next;
         sclk_reg   <= sclk_next;
         cs_reg     <= cs_next;
         mosi_reg   <= mosi_next;
         busy_reg   <= busy_next;
         done_reg   <= done_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      div_next    = div_reg;
      bit_next    = bit_reg;
      tx_next     = tx_reg;
      rx_next     = rx_reg;
      result_next = result_reg;
      sclk_next   = sclk_reg;
      cs_next     = cs_reg;
      mosi_next   = mosi_reg;
      busy_next   = busy_reg;
      done_next   = 1'b0;
      case (state_reg)
         IDLE: begin
            sclk_next = 1'b0;
            cs_next   = 1'b1;
            mosi_next = 1'b0;
            busy_next = 1'b0;
            // done_reg high means this is the done cycle; a start here is dropped
            if (start && !done_reg) begin
               state_next = SETUP;
               tx_next    = {msg_in, key_in};
               mosi_next  = msg_in[32*nb-1];
               cs_next    = 1'b0;
               busy_next  = 1'b1;
               div_next   = HALF_LEN;
            end
         end
         SETUP: begin
            if (div_reg == '0) begin
               state_next = TX;
               div_next   = HALF_LEN;
               bit_next   = TX_LEN;
               mosi_next  = tx_reg[TX_BITS-1];
            end else begin
               div_next = div_reg - DIV_ONE;
            end
         end
         TX: begin
            if (div_reg != '0) begin
               div_next = div_reg - DIV_ONE;
            end else if (!sclk_reg) begin
               sclk_next = 1'b1;
               div_next  = HALF_LEN;
            end else begin
               sclk_next = 1'b0;
               div_next  = HALF_LEN;
               if (bit_reg == CNT_ONE) begin
                  state_next = GAP;
                  bit_next   = '0;
                  mosi_next  = 1'b0;
                  div_next   = GAP_LEN;
               end else begin
                  bit_next  = bit_reg - CNT_ONE;
                  tx_next   = {tx_reg[TX_BITS-2:0], 1'b0};
                  mosi_next = tx_reg[TX_BITS-2];
               end
            end
         end
         GAP: begin
            if (div_reg == '0) begin
               state_next = RX;
               div_next   = HALF_LEN;
               bit_next   = RX_LEN;
            end else begin
               div_next = div_reg - DIV_ONE;
            end
         end
         RX: begin
            mosi_next = 1'b0;
            // after the last period a final low half keeps cs asserted past the last edge
            if (div_reg != '0) begin
               div_next = div_reg - DIV_ONE;
            end else if (!sclk_reg) begin
               if (bit_reg == '0) begin
                  state_next  = FINISH;
                  cs_next     = 1'b1;
                  result_next = rx_reg;
               end else begin
                  sclk_next = 1'b1;
                  div_next  = HALF_LEN;
                  rx_next   = {rx_reg[RX_BITS-2:0], miso};
               end
            end else begin
               sclk_next = 1'b0;
               div_next  = HALF_LEN;
               bit_next  = bit_reg - CNT_ONE;
            end
         end
         FINISH: begin
            sclk_next  = 1'b0;
            cs_next    = 1'b1;
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign sclk       = sclk_reg;
   assign cs         = cs_reg;
   assign mosi       = mosi_reg;
   assign busy       = busy_reg;
   assign done       = done_reg;
   assign result_out = result_reg;

endmodule

// File: tb/tb_spi_aes_initiator.sv
// Bench for spi_aes_initiator: a subnode model captures mosi, returns a response block,
// and frames are checked against the expected bit stream, result and latency.
module tb_spi_aes_initiator;

   localparam int NB  = 4;
   localparam int NK  = 8;
   localparam int TXB = 32*(NB+NK);
   localparam int RXB = 32*NB;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic            start = 1'b0, start1 = 1'b0;
   logic [RXB-1:0]  msg_in = '0;
   logic [32*NK-1:0] key_in = '0;
   logic            miso = 1'b0;
   logic            miso1 = 1'b1;
   logic            sclk, cs, mosi, busy, done;
   logic [RXB-1:0]  result_out;
   logic            sclk1, cs1, mosi1, busy1, done1;
   logic [RXB-1:0]  result_out1;

   spi_aes_initiator #(.nk(NK), .nb(NB), .CLK_DIV(2)) dut (
      .in_clk(clk), .rst(rst), .start(start), .msg_in(msg_in), .key_in(key_in),
      .miso(miso), .sclk(sclk), .cs(cs), .mosi(mosi), .busy(busy), .done(done),
      .result_out(result_out));

   spi_aes_initiator #(.nk(NK), .nb(NB), .CLK_DIV(1)) dut1 (
      .in_clk(clk), .rst(rst), .start(start1), .msg_in(msg_in), .key_in(key_in),
      .miso(miso1), .sclk(sclk1), .cs(cs1), .mosi(mosi1), .busy(busy1), .done(done1),
      .result_out(result_out1));

   int errors = 0;
   int checks = 0;

   // Subnode model: samples mosi on every sclk rise, serves the response after the TX phase.
   int             rise_cnt = 0;
   int             done_cnt = 0;
   int             rx_mosi_ones = 0;
   bit             cap_q[$];
   logic [RXB-1:0] resp_model = '0;
   logic           sclk_q = 1'b0;

   always @(negedge clk) begin
      if (sclk && !sclk_q) begin
         rise_cnt++;
         if (rise_cnt <= TXB) cap_q.push_back(mosi);
         else if (mosi) rx_mosi_ones++;
         if (rise_cnt >= TXB && rise_cnt < TXB+RXB)
            miso = resp_model[RXB-1-(rise_cnt-TXB)];
      end
      if (done) done_cnt++;
      sclk_q = sclk;
   end

   task automatic check_vec(input string name, input logic [383:0] act, input logic [383:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int exp_latency(input int c);
      return 2*c*(32*NB + 32*NK + 32*NB + 2) + 1;
   endfunction

   function automatic logic [RXB-1:0] rand_blk();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic start_frame(input logic [RXB-1:0] m, input logic [32*NK-1:0] k,
                              input logic [RXB-1:0] r, output logic cs_before);
      @(negedge clk);
      cs_before    = cs;
      msg_in       = m;
      key_in       = k;
      resp_model   = r;
      rise_cnt     = 0;
      done_cnt     = 0;
      rx_mosi_ones = 0;
      cap_q.delete();
      miso         = 1'b0;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Returns at the negedge where done is seen (or when the budget runs out).
   task automatic wait_done(input bit inject, output int lat);
      int cyc = 0;
      bit injected = 0;
      while (!done && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         if (inject && !injected && rise_cnt >= 100) begin
            start    = 1'b1;
            msg_in   = ~msg_in;
            key_in   = ~key_in;
            injected = 1;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      lat = cyc;
   endtask

   task automatic check_frame(input string tag, input logic [RXB-1:0] m, input logic [32*NK-1:0] k,
                              input logic [RXB-1:0] r, input int lat, input int exp_lat);
      bit exp_q[$];
      int bad = -1;
      for (int i = RXB-1; i >= 0; i--) exp_q.push_back(m[i]);
      for (int i = 32*NK-1; i >= 0; i--) exp_q.push_back(k[i]);
      if (cap_q.size() != exp_q.size()) bad = cap_q.size();
      else
         for (int i = 0; i < exp_q.size(); i++)
            if (bad < 0 && cap_q[i] != exp_q[i]) bad = i;
      check_int({tag, " latency"}, lat, exp_lat);
      check_vec({tag, " result"}, 384'(result_out), 384'(r));
      check_int({tag, " sclk rises"}, rise_cnt, TXB+RXB);
      check_int({tag, " mosi first bad bit"}, bad, -1);
      check_int({tag, " mosi ones in rx"}, rx_mosi_ones, 0);
      check_vec({tag, " busy at done"}, 384'(busy), 384'(0));
      check_vec({tag, " cs at done"}, 384'(cs), 384'(1));
      $display("frame %s: msg=%h lat=%0d result=%h", tag, m, lat, result_out);
   endtask

   typedef struct {
      logic [RXB-1:0]   msg;
      logic [32*NK-1:0] key;
      logic [RXB-1:0]   resp;
      bit               inject;
      int               exp_lat;
      logic [RXB-1:0]   exp_result;
   } vec_t;

   localparam logic [RXB-1:0]   SPEC_MSG  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [32*NK-1:0] SPEC_KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [RXB-1:0]   SPEC_RESP = 128'h8ea2b7ca516745bfeafc49904b496089;

   initial begin
      vec_t vecs[4];
      int   lat;
      logic csb;
      logic [RXB-1:0] m, r;
      logic [32*NK-1:0] k;

      vecs[0] = '{SPEC_MSG, SPEC_KEY, SPEC_RESP, 1'b0, 2057, SPEC_RESP};
      vecs[1] = '{{RXB{1'b1}}, '0, '0, 1'b0, 2057, '0};
      vecs[2] = '{SPEC_MSG, SPEC_KEY, SPEC_RESP, 1'b1, 2057, SPEC_RESP};
      vecs[3] = '{{32{4'ha}}, {64{4'h5}}, {32{4'hc}}, 1'b0, 2057, {32{4'hc}}};

      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_vec("reset sclk", 384'(sclk), 384'(0));
      check_vec("reset cs", 384'(cs), 384'(1));
      check_vec("reset mosi", 384'(mosi), 384'(0));
      check_vec("reset busy", 384'(busy), 384'(0));
      check_vec("reset done", 384'(done), 384'(0));
      check_vec("reset result", 384'(result_out), 384'(0));
      check_vec("reset cs div1", 384'(cs1), 384'(1));

      for (int i = 0; i < 4; i++) begin
         start_frame(vecs[i].msg, vecs[i].key, vecs[i].resp, csb);
         wait_done(vecs[i].inject, lat);
         check_frame($sformatf("vec%0d", i), vecs[i].msg, vecs[i].key, vecs[i].exp_result, lat, vecs[i].exp_lat);
         repeat (4) @(negedge clk);
         check_int($sformatf("vec%0d done pulses", i), done_cnt, 1);
         check_vec($sformatf("vec%0d idle after", i), 384'(busy), 384'(0));
      end

      for (int i = 0; i < 3; i++) begin
         m = rand_blk();
         k = {rand_blk(), rand_blk()};
         r = rand_blk();
         start_frame(m, k, r, csb);
         wait_done(1'b0, lat);
         check_frame($sformatf("rand%0d", i), m, k, r, lat, exp_latency(2));
      end

      // start during the done cycle must be dropped
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check_vec("start in done cycle busy", 384'(busy), 384'(0));
      check_vec("start in done cycle cs", 384'(cs), 384'(1));
      check_vec("result held after start", 384'(result_out), 384'(r));

      // back-to-back frames: second start in the cycle right after done
      start_frame(SPEC_MSG, SPEC_KEY, SPEC_RESP, csb);
      wait_done(1'b0, lat);
      check_frame("b2b_a", SPEC_MSG, SPEC_KEY, SPEC_RESP, lat, 2057);
      m = rand_blk();
      r = rand_blk();
      start_frame(m, SPEC_KEY, r, csb);
      check_vec("b2b cs high between frames", 384'(csb), 384'(1));
      wait_done(1'b0, lat);
      check_frame("b2b_b", m, SPEC_KEY, r, lat, 2057);

      // reset in the middle of TX
      start_frame(SPEC_MSG, SPEC_KEY, SPEC_RESP, csb);
      for (int c = 0; c < 3000 && rise_cnt < 200; c++) @(negedge clk);
      check_int("reached tx bit 200", rise_cnt, 200);
      rst = 1'b1;
      #1;
      check_vec("mid-tx reset cs", 384'(cs), 384'(1));
      check_vec("mid-tx reset sclk", 384'(sclk), 384'(0));
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_int("mid-tx reset done pulses", done_cnt, 0);
      check_vec("mid-tx reset result", 384'(result_out), 384'(0));
      check_vec("mid-tx reset busy", 384'(busy), 384'(0));
      start_frame(SPEC_MSG, SPEC_KEY, SPEC_RESP, csb);
      wait_done(1'b0, lat);
      check_frame("after_reset", SPEC_MSG, SPEC_KEY, SPEC_RESP, lat, 2057);

      // CLK_DIV=1 instance with miso tied high
      @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      lat = 0;
      while (!done1 && lat < 3000) begin
         @(negedge clk);
         lat++;
      end
      check_int("div1 latency", lat, exp_latency(1));
      check_vec("div1 result", 384'(result_out1), 384'({RXB{1'b1}}));
      check_vec("div1 cs at done", 384'(cs1), 384'(1));
      $display("frame div1: lat=%0d result=%h", lat, result_out1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
